uart2_rx: RTL and testbench
===========================

// Module: uart2_rx
// PURPOSE
//   UART receiver, the receive-side counterpart of the uart2 transmitter. Converts serial 8N1 frames on rx_i
//   into bytes with a valid/ready output handshake. Feeds the 8-to-64 collect FSM on the receive path.
//   Framing errors and overruns are reported as one-cycle status pulses.
//   State register type is uart2_pkgs::state_encoding: IDLE_STATE, START_STATE, MOVE_DATA_STATE, STOP_STATE.
// PARAMETERS
//   CLK_FREQ    100_000_000  system clock frequency, Hz
//   BAUD        115_200      line rate, bit/s
//   OVERSAMPLE  16           sample ticks per bit; must be an even value >= 4
//   DATA_BITS   8            data bits per frame, LSB first
//   DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer truncation. DIV < 1 is an elaboration error ($error).
// PORTS
//   clk          in   1          system clock; all logic on the rising edge
//   rst_n        in   1          synchronous reset, active low
//   rx_i         in   1          serial input, asynchronous, idles high
//   rx_data_o    out  DATA_BITS  received byte; held stable while rx_valid_o = 1
//   rx_valid_o   out  1          byte available
//   rx_ready_i   in   1          consumer accepts the byte when rx_valid_o && rx_ready_i
//   frame_err_o  out  1          1-cycle pulse: stop bit sampled as 0
//   overrun_o    out  1          1-cycle pulse: good frame completed while the held byte was not accepted
//   busy_o       out  1          1 while the FSM is not in IDLE_STATE
// BEHAVIOUR
//   Reset (rst_n = 0 at a clk edge):
//     - FSM goes to IDLE_STATE. Tick counter, sample counter and bit counter clear.
//     - Synchronizer flops are set to 1.
//     - All outputs are 0: rx_data_o = 0, rx_valid_o = 0, frame_err_o = 0, overrun_o = 0, busy_o = 0.
//     - A frame in progress is abandoned; reset mid-frame is not an error.
//   Input synchronizer: two flops on rx_i giving rx_s. A third flop holds rx_s from the previous cycle
//     for falling-edge detection.
//   Tick generator: 1-cycle tick every DIV clocks. The counter restarts at 0 on entry to START_STATE.
//   Sample counter sc: 0..OVERSAMPLE-1, advances on each tick. Bit counter bc: 0..DATA_BITS-1.
//   IDLE_STATE:
//     - A falling edge on rx_s (previous = 1, now = 0) moves to START_STATE. sc is cleared.
//     - A line held low (break condition) never starts a frame; a rising edge must come first.
//   START_STATE: on the tick where sc = OVERSAMPLE/2-1 (mid start bit), sample rx_s.
//     - rx_s = 0: go to MOVE_DATA_STATE with sc = 0 and bc = 0.
//     - rx_s = 1: glitch; return to IDLE_STATE silently.
//   MOVE_DATA_STATE:
//     - On each tick where sc = OVERSAMPLE-1, shift rx_s in at the MSB of the shift register
//       (shift right, LSB first on the line).
//     - After DATA_BITS samples, go to STOP_STATE with sc = 0.
//   STOP_STATE: on the tick where sc = OVERSAMPLE-1 (mid stop bit), sample rx_s, then go to IDLE_STATE.
//     - rx_s = 1: good frame; handled by the output handshake below.
//     - rx_s = 0: frame_err_o pulses for 1 cycle; the byte is discarded and rx_valid_o is unchanged.
//   Output handshake (evaluated in the cycle the mid-stop sample is taken):
//     - valid = 0, or (valid = 1 and ready = 1): on the next edge, rx_data_o = shift register and rx_valid_o = 1.
//     - valid = 1 and ready = 0: new byte dropped; rx_data_o is kept; overrun_o pulses 1 cycle.
//     - Otherwise, when valid = 1 and ready = 1, rx_valid_o clears on the next edge.
//     - Latency: rx_valid_o rises 1 clk after the mid-stop sample tick.
//   frame_err_o and overrun_o can never pulse in the same cycle.
// TESTING
//   Bench parameters: CLK_FREQ = 1_600_000, BAUD = 100_000, OVERSAMPLE = 16, so DIV = 1 and one bit = 16 clk.
//   1. Send 0xA5 as 8N1 with rx_ready_i = 1.
//      -> rx_valid_o for 1 cycle, rx_data_o = 0xA5, frame_err_o = 0.
//      -> rx_valid_o rises 2 + 8 + 8*16 + 16 + 1 = 155 clk (±1) after the falling edge on rx_i.
//   2. Pulse rx_i low for 4 clk, then hold it high.
//      -> busy_o drops 8 clk after entering START_STATE.
//      -> No rx_valid_o and no frame_err_o.
//   3. Send 0x3C with the stop bit driven to 0.
//      -> frame_err_o pulses exactly 1 cycle; rx_valid_o stays 0.
//      -> With rx_i held 0, no new frame starts until rx_i returns high and then falls.
//   4. Send 0x11 then 0x22 back-to-back with rx_ready_i = 0.
//      -> rx_data_o = 0x11 with rx_valid_o = 1 held.
//      -> overrun_o pulses at the end of 0x22; rx_data_o is still 0x11.
//   5. Hold rx_valid_o = 1 (0x11) and raise rx_ready_i in the same cycle as the 0x22 mid-stop sample.
//      -> Next cycle: rx_data_o = 0x22, rx_valid_o = 1, overrun_o = 0.
//   6. Assert rst_n = 0 for 1 clk during bit 4 of 0x77; then send 0x5A.
//      -> Outputs are 0 in the cycle after reset; no frame_err_o.
//      -> 0x5A is received correctly.

Source files
------------

// File: rtl/uart2_rx.sv
// rtl/uart2_rx.sv - oversampling 8N1 UART receiver with valid/ready byte output and error pulses.
package uart2_pkgs;
    typedef enum logic [1:0] {
        IDLE_STATE,
        START_STATE,
        MOVE_DATA_STATE,
        STOP_STATE
    } state_encoding;
endpackage

module uart2_rx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);
    import uart2_pkgs::*;

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] TC_LAST = TW'(DIV - 1);
    localparam logic [SW-1:0] SC_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SC_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BC_LAST = BW'(DATA_BITS - 1);

    generate
        if (DIV < 1) begin : g_div_check
            $error("uart2_rx: CLK_FREQ/(BAUD*OVERSAMPLE) must be at least 1");
        end
        if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_os_check
            $error("uart2_rx: OVERSAMPLE must be even and >= 4");
        end
    endgenerate

    state_encoding        state_q, state_d;
    logic [TW-1:0]        tc_q, tc_d;
    logic [SW-1:0]        sc_q, sc_d;
    logic [BW-1:0]        bc_q, bc_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 rx_meta_q, rx_s_q, rx_prev_q;
    logic                 tick;

    // Synchronizer flops reset high so a line idling high never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign tick = (tc_q == TC_LAST);

    always_comb begin
        state_d = state_q;
        tc_d    = tick ? '0 : tc_q + 1'b1;
        sc_d    = sc_q;
        bc_d    = bc_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q && !rx_ready_i;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        case (state_q)
            IDLE_STATE: begin
                // Holding the tick counter at 0 here restarts it on entry to START_STATE.
                tc_d = '0;
                sc_d = '0;
                if (rx_prev_q && !rx_s_q) begin
                    state_d = START_STATE;
                end
            end
            START_STATE: begin
                if (tick) begin
                    if (sc_q == SC_MID) begin
                        sc_d = '0;
                        bc_d = '0;
                        state_d = rx_s_q ? IDLE_STATE : MOVE_DATA_STATE;
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
            end
            MOVE_DATA_STATE: begin
                if (tick) begin
                    if (sc_q == SC_LAST) begin
                        sc_d    = '0;
                        shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        if (bc_q == BC_LAST) begin
                            state_d = STOP_STATE;
                        end else begin
                            bc_d = bc_q + 1'b1;
                        end
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
            end
            STOP_STATE: begin
                if (tick) begin
                    if (sc_q == SC_LAST) begin
                        sc_d    = '0;
                        state_d = IDLE_STATE;
                        if (!rx_s_q) begin
                            ferr_d = 1'b1;
                        end else if (!valid_q || rx_ready_i) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE_STATE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE_STATE;
            tc_q    <= '0;
            sc_q    <= '0;
            bc_q    <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
            sc_q    <= sc_d;
            bc_q    <= bc_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_data_o   = data_q;
    assign rx_valid_o  = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
    assign busy_o      = (state_q != IDLE_STATE);

endmodule

// File: tb/tb_uart2_rx.sv
// tb/tb_uart2_rx.sv - scoreboard bench for uart2_rx at DIV = 1, 16 clk per bit.
module tb_uart2_rx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_i = 1'b1;
    logic       rx_ready_i = 1'b0;
    logic [7:0] rx_data_o;
    logic       rx_valid_o, frame_err_o, overrun_o, busy_o;

    uart2_rx #(
        .CLK_FREQ  (1_600_000),
        .BAUD      (100_000),
        .OVERSAMPLE(16),
        .DATA_BITS (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_i       (rx_i),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .rx_ready_i (rx_ready_i),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];
    int         ferr_cnt = 0, ovr_cnt = 0, busy_cnt = 0, valid_cnt = 0, rise_cnt = 0;
    int         last_rise = 0;
    logic       valid_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected byte on every accepted handshake, tallies status pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err_o) ferr_cnt++;
            if (overrun_o) ovr_cnt++;
            if (busy_o) busy_cnt++;
            if (rx_valid_o) valid_cnt++;
            if (rx_valid_o && !valid_prev) begin
                rise_cnt++;
                last_rise = cyc;
            end
            if (frame_err_o && overrun_o) check("ferr_ovr_same_cycle", 1, 0);
            if (rx_valid_o && rx_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", int'(rx_data_o), -1);
                end else begin
                    check("rx_byte", int'(rx_data_o), int'(exp_q.pop_front()));
                end
            end
        end
        valid_prev = rx_valid_o;
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives ncyc clocks of an 8N1 frame; the caller is always 1 time unit past a rising edge.
    task automatic drive_frame(input logic [7:0] d, input logic stop, input int ncyc,
                               input bit late_ready, output int e0);
        e0 = cyc;
        for (int c = 0; c < ncyc; c++) begin
            if (late_ready && c == 155) begin
                check("t5_data", int'(rx_data_o), 'h22);
                check("t5_valid", int'(rx_valid_o), 1);
                check("t5_overrun", int'(overrun_o), 0);
            end
            if (c < 16)       rx_i = 1'b0;
            else if (c < 144) rx_i = d[3'((c - 16) / 16)];
            else              rx_i = stop;
            if (late_ready && c == 154) rx_ready_i = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int e0, f0, o0, b0, r0, v0;
        int lat;
        idle(3);
        check("rst_data", int'(rx_data_o), 0);
        check("rst_valid", int'(rx_valid_o), 0);
        check("rst_ferr", int'(frame_err_o), 0);
        check("rst_ovr", int'(overrun_o), 0);
        check("rst_busy", int'(busy_o), 0);
        rst_n = 1'b1;
        idle(10);

        // 1: clean 0xA5 with the consumer always ready
        rx_ready_i = 1'b1;
        f0 = ferr_cnt; r0 = rise_cnt; v0 = valid_cnt;
        exp_q.push_back(8'hA5);
        drive_frame(8'hA5, 1'b1, 160, 1'b0, e0);
        idle(10);
        lat = last_rise - e0;
        check("t1_latency_in_window", int'(lat >= 154 && lat <= 156), 1);
        check("t1_rises", rise_cnt - r0, 1);
        check("t1_valid_cycles", valid_cnt - v0, 1);
        check("t1_ferr", ferr_cnt - f0, 0);

        // 2: 4-clk glitch is rejected at the mid start-bit sample
        f0 = ferr_cnt; r0 = rise_cnt; b0 = busy_cnt;
        rx_i = 1'b0;
        idle(4);
        rx_i = 1'b1;
        idle(30);
        check("t2_busy_cycles", busy_cnt - b0, 8);
        check("t2_rises", rise_cnt - r0, 0);
        check("t2_ferr", ferr_cnt - f0, 0);

        // 3: stop bit low gives one frame-error cycle; held-low line does not restart
        f0 = ferr_cnt; r0 = rise_cnt;
        drive_frame(8'h3C, 1'b0, 160, 1'b0, e0);
        b0 = busy_cnt;
        idle(200);
        check("t3_ferr_cycles", ferr_cnt - f0, 1);
        check("t3_rises", rise_cnt - r0, 0);
        check("t3_valid", int'(rx_valid_o), 0);
        check("t3_break_busy", busy_cnt - b0, 0);
        rx_i = 1'b1;
        idle(20);

        // 4: two frames back-to-back while the consumer stalls
        rx_ready_i = 1'b0;
        o0 = ovr_cnt; f0 = ferr_cnt;
        exp_q.push_back(8'h11);
        drive_frame(8'h11, 1'b1, 160, 1'b0, e0);
        check("t4_first_data", int'(rx_data_o), 'h11);
        check("t4_first_valid", int'(rx_valid_o), 1);
        drive_frame(8'h22, 1'b1, 160, 1'b0, e0);
        idle(10);
        check("t4_overrun_cycles", ovr_cnt - o0, 1);
        check("t4_kept_data", int'(rx_data_o), 'h11);
        check("t4_kept_valid", int'(rx_valid_o), 1);

        // 5: ready rises in the cycle of the mid-stop sample of 0x22
        o0 = ovr_cnt;
        exp_q.push_back(8'h22);
        drive_frame(8'h22, 1'b1, 160, 1'b1, e0);
        idle(10);
        check("t5_overrun_cycles", ovr_cnt - o0, 0);
        check("t5_drained", int'(rx_valid_o), 0);

        // 6: reset during bit 4 of 0x77 abandons it; 0x5A is then received
        f0 = ferr_cnt;
        drive_frame(8'h77, 1'b1, 16 + 4 * 16 + 8, 1'b0, e0);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        rx_i = 1'b1;
        check("t6_data", int'(rx_data_o), 0);
        check("t6_valid", int'(rx_valid_o), 0);
        check("t6_ferr", int'(frame_err_o), 0);
        check("t6_ovr", int'(overrun_o), 0);
        check("t6_busy", int'(busy_o), 0);
        idle(40);
        exp_q.push_back(8'h5A);
        drive_frame(8'h5A, 1'b1, 160, 1'b0, e0);
        idle(20);
        check("t6_ferr_cycles", ferr_cnt - f0, 0);
        check("bytes_outstanding", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
